bin_bbox_overlay: RTL and testbench
===================================

Name: bin_bbox_overlay

Overview:
- Sink for the 1-bit thresholded camera stream (pixel bit plus de/hs/vs).
- Per frame, tracks the bounding box and the pixel count of all '1' pixels.
- At each frame boundary, latches the result and pulses box_valid.
- Re-emits the stream as RGB565 for the 480-wide LCD path: '1' pixels white, '0' pixels black, previous frame's box drawn as a 1-pixel outline in BOX_COLOR.

Parameters:
- H_ACTIVE, 480, active pixels per line; pixels at x >= H_ACTIVE are ignored for tracking.
- V_ACTIVE, 272, active lines per frame; lines at y >= V_ACTIVE are ignored for tracking.
- MIN_PIXELS, 64, minimum '1' count for a frame to report a box as found.
- BOX_COLOR, 16'hF800, RGB565 outline colour.
- VS_POL, 1'b1, active level of bin_vs; frame start is the edge into the active level.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- bin_data  in  1  thresholded pixel, 1 = target
- bin_de  in  1  data enable
- bin_hs  in  1  hsync, delayed to output only
- bin_vs  in  1  vsync
- out_data  out  16  RGB565 pixel
- out_de  out  1  delayed bin_de
- out_hs  out  1  delayed bin_hs
- out_vs  out  1  delayed bin_vs
- box_found  out  1  last completed frame had count >= MIN_PIXELS
- box_xmin  out  11  left edge
- box_xmax  out  11  right edge
- box_ymin  out  10  top edge
- box_ymax  out  10  bottom edge
- box_count  out  19  '1' pixels in last frame, saturating at 2^19-1
- box_valid  out  1  one-cycle pulse when the box_* outputs update

Behaviour:
- Reset: every output is 0; all counters and accumulators are cleared; FSM enters WAIT_VS.
- Frame-start detection: vs_start = bin_vs at VS_POL this cycle and at the opposite level in the previous registered sample.
- x counter: increments on every bin_de=1 cycle and clears on the cycle after bin_de falls.
- y counter: increments on each bin_de falling edge and clears on vs_start.
- Tracking qualifier: a pixel is tracked when bin_de=1, bin_data=1, x < H_ACTIVE and y < V_ACTIVE.
- Tracked pixel: acc_xmin = min(acc_xmin, x); acc_xmax = max; likewise for y; acc_count += 1, saturating.
- Accumulator initial state: acc_xmin = H_ACTIVE-1, acc_xmax = 0, acc_ymin = V_ACTIVE-1, acc_ymax = 0, acc_count = 0.
- FSM WAIT_VS: no tracking; on vs_start go to TRACK and clear the accumulators. This discards any partial frame after reset.
- FSM TRACK: tracks pixels; on vs_start go to LATCH.
- FSM LATCH (exactly 1 cycle):
  - Copies the accumulators to the box_* outputs.
  - box_found = (acc_count >= MIN_PIXELS).
  - box_valid = 1.
  - Clears the accumulators, then returns to TRACK.
- Not-found frame: if the count is below MIN_PIXELS, box_found = 0 and the edge/count outputs still update.
- vs_start coinciding with bin_de=1: the frame boundary wins; that pixel is not tracked.
- vs_start during LATCH: cannot legally occur; it is ignored.
- Video path latency: exactly 1 cycle. out_de, out_hs and out_vs are registered copies of the inputs; out_data is registered in the same cycle.
- out_data priority:
  - bin_de=0 → 16'h0000.
  - Else, if box_found and the pixel lies on the outline of the latched box → BOX_COLOR. Outline = x ∈ {xmin, xmax} with ymin ≤ y ≤ ymax, or y ∈ {ymin, ymax} with xmin ≤ x ≤ xmax.
  - Else bin_data ? 16'hFFFF : 16'h0000.
- Outline source: the overlay uses the box_* registers, so it always shows the previous frame's box.
- Counter overflow: x and y saturate at their maximum widths and never wrap.
- Reset mid-frame: all outputs clear asynchronously, then the FSM resynchronises via WAIT_VS. No box_valid is emitted until one full frame has been tracked.

Decomposition:
- Shared package: X_W=11, Y_W=10 and CNT_W=19 constants; the FSM state encoding (WAIT_VS, TRACK, LATCH); RGB565 constants WHITE and BLACK.
- One natural sub-module: bin_pos_counter. It generates x, y and vs_start from de/vs and is reusable by other stream consumers.
- The min/max accumulator and overlay logic stay in the top level.

Test Plan:
- Reset, then 480x272 frames all zero → no box_valid before the second vs_start. After each later frame: box_valid pulse, box_found=0, box_count=0, out_data all 16'h0000.
- Solid 20x10 block of ones at x 100..119, y 50..59 → at LATCH: xmin=100, xmax=119, ymin=50, ymax=59, count=200, found=1. In the next frame, out_data=16'hF800 exactly on the outline pixels, 1 cycle after the input.
- Only 10 ones in a frame (below MIN_PIXELS=64) → box_found=0, box_count=10, and no outline is drawn in the next frame.
- Ones at x=479 and at the (illegal) 481st pixel of a line → xmax=479; the out-of-range pixel is not counted.
- vs_start coinciding with a de=1, data=1 pixel → that pixel is excluded from both frames' counts, and box_valid is exactly 1 cycle wide.
- rst_n asserted mid-frame with ones present → all outputs 0 immediately. The first post-reset partial frame produces no box_valid; the next full frame reports correct values.

Source files
------------

// File: rtl/bin_bbox_overlay_pkg.sv
// Shared widths, FSM encoding and colour constants for the binary bounding-box overlay.
package bin_bbox_overlay_pkg;

    localparam int unsigned X_W   = 11;
    localparam int unsigned Y_W   = 10;
    localparam int unsigned CNT_W = 19;

    localparam logic [15:0] WHITE = 16'hFFFF;
    localparam logic [15:0] BLACK = 16'h0000;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        TRACK   = 2'd1,
        LATCH   = 2'd2
    } state_e;

endpackage

// File: rtl/bin_pos_counter.sv
// Pixel position tracker: x/y of the current pixel and frame-start detection from de/vs.
module bin_pos_counter
    import bin_bbox_overlay_pkg::*;
#(
    parameter logic VS_POL = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           de,
    input  logic           vs,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           vs_start_c
);

    logic           de_q, de_d;
    logic           vs_q, vs_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;

    // Counters hold the coordinates of the pixel currently on the input; both saturate.
    always_comb begin
        de_d       = de;
        vs_d       = vs;
        vs_start_c = (vs == VS_POL) && (vs_q != VS_POL);
        x_d        = x_q;
        y_d        = y_q;
        if (de) begin
            if (x_q != '1) x_d = x_q + X_W'(1);
        end else begin
            x_d = '0;
        end
        if (vs_start_c) begin
            y_d = '0;
        end else if (!de && de_q && (y_q != '1)) begin
            y_d = y_q + Y_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q <= 1'b0;
            vs_q <= ~VS_POL;
            x_q  <= '0;
            y_q  <= '0;
        end else begin
            de_q <= de_d;
            vs_q <= vs_d;
            x_q  <= x_d;
            y_q  <= y_d;
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: rtl/bin_bbox_overlay.sv
// Tracks the bounding box of '1' pixels per frame and re-emits the stream as RGB565
// with the previous frame's box outlined.
module bin_bbox_overlay
    import bin_bbox_overlay_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 480,
    parameter int unsigned V_ACTIVE   = 272,
    parameter int unsigned MIN_PIXELS = 64,
    parameter logic [15:0] BOX_COLOR  = 16'hF800,
    parameter logic        VS_POL     = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bin_data,
    input  logic             bin_de,
    input  logic             bin_hs,
    input  logic             bin_vs,
    output logic [15:0]      out_data,
    output logic             out_de,
    output logic             out_hs,
    output logic             out_vs,
    output logic             box_found,
    output logic [X_W-1:0]   box_xmin,
    output logic [X_W-1:0]   box_xmax,
    output logic [Y_W-1:0]   box_ymin,
    output logic [Y_W-1:0]   box_ymax,
    output logic [CNT_W-1:0] box_count,
    output logic             box_valid
);

    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;
    logic           vs_start_c;

    bin_pos_counter #(.VS_POL(VS_POL)) u_pos (
        .clk        (clk),
        .rst_n      (rst_n),
        .de         (bin_de),
        .vs         (bin_vs),
        .x          (pix_x),
        .y          (pix_y),
        .vs_start_c (vs_start_c)
    );

    state_e state_q, state_d;

    logic [X_W-1:0]   acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
    logic [Y_W-1:0]   acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
    logic [CNT_W-1:0] acc_count_q, acc_count_d;

    logic [X_W-1:0]   box_xmin_q, box_xmin_d, box_xmax_q, box_xmax_d;
    logic [Y_W-1:0]   box_ymin_q, box_ymin_d, box_ymax_q, box_ymax_d;
    logic [CNT_W-1:0] box_count_q, box_count_d;
    logic             box_found_q, box_found_d;
    logic             box_valid_q, box_valid_d;

    logic [15:0] out_data_q, out_data_d;
    logic        out_de_q, out_de_d, out_hs_q, out_hs_d, out_vs_q, out_vs_d;

    localparam logic [X_W-1:0] XMIN_INIT = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] YMIN_INIT = Y_W'(V_ACTIVE - 1);

    logic track_c;
    logic on_outline_c;

    // A frame boundary on a valid pixel takes precedence: that pixel is never tracked.
    assign track_c = (state_q == TRACK) && !vs_start_c && bin_de && bin_data &&
                     (pix_x < X_W'(H_ACTIVE)) && (pix_y < Y_W'(V_ACTIVE));

    assign on_outline_c =
        (((pix_x == box_xmin_q) || (pix_x == box_xmax_q)) &&
         (pix_y >= box_ymin_q) && (pix_y <= box_ymax_q)) ||
        (((pix_y == box_ymin_q) || (pix_y == box_ymax_q)) &&
         (pix_x >= box_xmin_q) && (pix_x <= box_xmax_q));

    // Frame FSM with min/max accumulation and result latching.
    always_comb begin
        state_d     = state_q;
        acc_xmin_d  = acc_xmin_q;
        acc_xmax_d  = acc_xmax_q;
        acc_ymin_d  = acc_ymin_q;
        acc_ymax_d  = acc_ymax_q;
        acc_count_d = acc_count_q;
        box_xmin_d  = box_xmin_q;
        box_xmax_d  = box_xmax_q;
        box_ymin_d  = box_ymin_q;
        box_ymax_d  = box_ymax_q;
        box_count_d = box_count_q;
        box_found_d = box_found_q;
        box_valid_d = 1'b0;

        case (state_q)
            WAIT_VS: begin
                if (vs_start_c) begin
                    state_d     = TRACK;
                    acc_xmin_d  = XMIN_INIT;
                    acc_xmax_d  = '0;
                    acc_ymin_d  = YMIN_INIT;
                    acc_ymax_d  = '0;
                    acc_count_d = '0;
                end
            end
            TRACK: begin
                if (vs_start_c) begin
                    state_d = LATCH;
                end else if (track_c) begin
                    if (pix_x < acc_xmin_q) acc_xmin_d = pix_x;
                    if (pix_x > acc_xmax_q) acc_xmax_d = pix_x;
                    if (pix_y < acc_ymin_q) acc_ymin_d = pix_y;
                    if (pix_y > acc_ymax_q) acc_ymax_d = pix_y;
                    if (acc_count_q != '1) acc_count_d = acc_count_q + CNT_W'(1);
                end
            end
            LATCH: begin
                box_xmin_d  = acc_xmin_q;
                box_xmax_d  = acc_xmax_q;
                box_ymin_d  = acc_ymin_q;
                box_ymax_d  = acc_ymax_q;
                box_count_d = acc_count_q;
                box_found_d = (acc_count_q >= CNT_W'(MIN_PIXELS));
                box_valid_d = 1'b1;
                acc_xmin_d  = XMIN_INIT;
                acc_xmax_d  = '0;
                acc_ymin_d  = YMIN_INIT;
                acc_ymax_d  = '0;
                acc_count_d = '0;
                state_d     = TRACK;
            end
            default: state_d = WAIT_VS;
        endcase
    end

    // One-cycle video path; the overlay always draws the previously latched box.
    always_comb begin
        out_de_d   = bin_de;
        out_hs_d   = bin_hs;
        out_vs_d   = bin_vs;
        out_data_d = BLACK;
        if (bin_de) begin
            if (box_found_q && on_outline_c) begin
                out_data_d = BOX_COLOR;
            end else if (bin_data) begin
                out_data_d = WHITE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_VS;
            acc_xmin_q  <= XMIN_INIT;
            acc_xmax_q  <= '0;
            acc_ymin_q  <= YMIN_INIT;
            acc_ymax_q  <= '0;
            acc_count_q <= '0;
            box_xmin_q  <= '0;
            box_xmax_q  <= '0;
            box_ymin_q  <= '0;
            box_ymax_q  <= '0;
            box_count_q <= '0;
            box_found_q <= 1'b0;
            box_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_de_q    <= 1'b0;
            out_hs_q    <= 1'b0;
            out_vs_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_xmin_q  <= acc_xmin_d;
            acc_xmax_q  <= acc_xmax_d;
            acc_ymin_q  <= acc_ymin_d;
            acc_ymax_q  <= acc_ymax_d;
            acc_count_q <= acc_count_d;
            box_xmin_q  <= box_xmin_d;
            box_xmax_q  <= box_xmax_d;
            box_ymin_q  <= box_ymin_d;
            box_ymax_q  <= box_ymax_d;
            box_count_q <= box_count_d;
            box_found_q <= box_found_d;
            box_valid_q <= box_valid_d;
            out_data_q  <= out_data_d;
            out_de_q    <= out_de_d;
            out_hs_q    <= out_hs_d;
            out_vs_q    <= out_vs_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_de    = out_de_q;
    assign out_hs    = out_hs_q;
    assign out_vs    = out_vs_q;
    assign box_found = box_found_q;
    assign box_xmin  = box_xmin_q;
    assign box_xmax  = box_xmax_q;
    assign box_ymin  = box_ymin_q;
    assign box_ymax  = box_ymax_q;
    assign box_count = box_count_q;
    assign box_valid = box_valid_q;

endmodule

// File: tb/tb_bin_bbox_overlay.sv
// Bench for bin_bbox_overlay: directed frame table, random frames against a pixel-level
// reference model, plus frame-boundary and mid-frame reset sequences.
module tb_bin_bbox_overlay;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bin_data, bin_de, bin_hs, bin_vs;
    logic [15:0] out_data;
    logic        out_de, out_hs, out_vs;
    logic        box_found, box_valid;
    logic [10:0] box_xmin, box_xmax;
    logic [9:0]  box_ymin, box_ymax;
    logic [18:0] box_count;

    always #5 clk = ~clk;

    bin_bbox_overlay dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bin_data  (bin_data),
        .bin_de    (bin_de),
        .bin_hs    (bin_hs),
        .bin_vs    (bin_vs),
        .out_data  (out_data),
        .out_de    (out_de),
        .out_hs    (out_hs),
        .out_vs    (out_vs),
        .box_found (box_found),
        .box_xmin  (box_xmin),
        .box_xmax  (box_xmax),
        .box_ymin  (box_ymin),
        .box_ymax  (box_ymax),
        .box_count (box_count),
        .box_valid (box_valid)
    );

    int n_vec = 0;
    int n_err = 0;

    logic img [0:63][0:511];

    // Reference model: pixel coordinates, frame accumulators, latched and visible box.
    int mx, my;
    bit m_de_prev, m_vs_prev, m_track, m_skip;
    int a_xmin, a_xmax, a_ymin, a_ymax, a_cnt;
    int p_xmin, p_xmax, p_ymin, p_ymax, p_cnt;
    bit p_found;
    int v_xmin, v_xmax, v_ymin, v_ymax, v_cnt;
    bit v_found;
    int pend;
    logic [15:0] e_data;
    bit e_de, e_hs, e_vs;

    int got_valid_cycles, g_xmin, g_xmax, g_ymin, g_ymax, g_cnt, g_found;
    int red_cnt;

    typedef struct {
        int lines; int w;
        int rx0; int rx1; int ry0; int ry1;
        int xmin; int xmax; int ymin; int ymax; int cnt; int found; int red;
    } vec_t;
    vec_t tab [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic acc_clear();
        a_xmin = 479; a_xmax = 0; a_ymin = 271; a_ymax = 0; a_cnt = 0;
    endtask

    task automatic model_reset();
        mx = 0; my = 0; m_de_prev = 0; m_vs_prev = 0; m_track = 0; m_skip = 0;
        acc_clear();
        v_xmin = 0; v_xmax = 0; v_ymin = 0; v_ymax = 0; v_cnt = 0; v_found = 0;
        pend = 0;
        e_data = 16'h0000; e_de = 0; e_hs = 0; e_vs = 0;
    endtask

    task automatic fill_img(input int x0, input int x1, input int y0, input int y1);
        for (int yy = 0; yy < 64; yy++)
            for (int xx = 0; xx < 512; xx++)
                img[yy][xx] = 1'b0;
        for (int yy = y0; yy <= y1; yy++)
            for (int xx = x0; xx <= x1; xx++)
                img[yy][xx] = 1'b1;
    endtask

    // One clock: check last cycle's outputs, drive new inputs, advance the model.
    task automatic cycle(input bit de, input bit hs, input bit vs, input bit d);
        bit exp_valid, vss, outline;
        int px, py;
        @(posedge clk);
        #1;
        exp_valid = (pend == 1);
        if (pend > 0) pend--;
        if (exp_valid) begin
            v_xmin = p_xmin; v_xmax = p_xmax; v_ymin = p_ymin; v_ymax = p_ymax;
            v_cnt = p_cnt; v_found = p_found;
        end
        check("video", {out_data, out_de, out_hs, out_vs}, {e_data, e_de, e_hs, e_vs});
        check("box", {box_valid, box_found, box_xmin, box_xmax, box_ymin, box_ymax, box_count},
              {exp_valid, v_found, 11'(v_xmin), 11'(v_xmax), 10'(v_ymin), 10'(v_ymax), 19'(v_cnt)});
        if (box_valid) begin
            got_valid_cycles++;
            g_xmin = int'(box_xmin); g_xmax = int'(box_xmax);
            g_ymin = int'(box_ymin); g_ymax = int'(box_ymax);
            g_cnt = int'(box_count); g_found = int'(box_found);
        end
        if (out_data == 16'hF800) red_cnt++;

        bin_de = de; bin_hs = hs; bin_vs = vs; bin_data = d;

        vss = vs && !m_vs_prev;
        px = mx; py = my;
        outline = v_found &&
                  (((px == v_xmin || px == v_xmax) && py >= v_ymin && py <= v_ymax) ||
                   ((py == v_ymin || py == v_ymax) && px >= v_xmin && px <= v_xmax));
        e_data = !de ? 16'h0000 : outline ? 16'hF800 : d ? 16'hFFFF : 16'h0000;
        e_de = de; e_hs = hs; e_vs = vs;

        if (m_skip) begin
            m_skip = 0;
        end else if (vss) begin
            if (m_track) begin
                p_xmin = a_xmin; p_xmax = a_xmax; p_ymin = a_ymin; p_ymax = a_ymax;
                p_cnt = a_cnt; p_found = (a_cnt >= 64);
                pend = 2;
                m_skip = 1;
            end
            m_track = 1;
            acc_clear();
        end else if (m_track && de && d && px < 480 && py < 272) begin
            if (px < a_xmin) a_xmin = px;
            if (px > a_xmax) a_xmax = px;
            if (py < a_ymin) a_ymin = py;
            if (py > a_ymax) a_ymax = py;
            if (a_cnt < 524287) a_cnt++;
        end

        mx = de ? ((mx < 2047) ? mx + 1 : mx) : 0;
        if (vss) my = 0;
        else if (!de && m_de_prev && my < 1023) my++;
        m_de_prev = de;
        m_vs_prev = vs;
    endtask

    task automatic drive_lines(input int n, input int w);
        for (int yy = 0; yy < n; yy++) begin
            for (int xx = 0; xx < w; xx++) cycle(1, 0, 0, img[yy][xx]);
            cycle(0, 1, 0, 0);
            cycle(0, 1, 0, 0);
            cycle(0, 0, 0, 0);
            cycle(0, 0, 0, 0);
        end
    endtask

    task automatic vs_pulse();
        got_valid_cycles = 0;
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        repeat (4) cycle(0, 0, 0, 0);
    endtask

    initial begin
        tab[0] = '{8,   40,   1,   0,  0, -1, 479,   0, 271,  0,   0, 0,  0};
        tab[1] = '{62, 128, 100, 119, 50, 59, 100, 119,  50, 59, 200, 1,  0};
        tab[2] = '{62, 128,   1,   0,  0, -1, 479,   0, 271,  0,   0, 0, 56};
        tab[3] = '{8,   40,   5,  14,  3,  3,   5,  14,   3,  3,  10, 0,  0};
        tab[4] = '{8,   40,   0,   7,  0,  7,   0,   7,   0,  7,  64, 1,  0};
        tab[5] = '{8,   40,   0,   8,  0,  6,   0,   8,   0,  6,  63, 0, 28};
        tab[6] = '{4,  482, 479, 480,  1,  1, 479, 479,   1,  1,   1, 0,  0};

        rst_n = 1'b0;
        bin_data = 0; bin_de = 0; bin_hs = 0; bin_vs = 0;
        model_reset();
        red_cnt = 0;
        #1;
        check("reset_outputs", {out_data, out_de, out_hs, out_vs, box_valid, box_found,
              box_xmin, box_xmax, box_ymin, box_ymax, box_count}, '0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        vs_pulse();
        check("arm_no_valid", got_valid_cycles, 0);

        for (int i = 0; i < 7; i++) begin
            fill_img(tab[i].rx0, tab[i].rx1, tab[i].ry0, tab[i].ry1);
            red_cnt = 0;
            drive_lines(tab[i].lines, tab[i].w);
            check("outline_pixels", red_cnt, tab[i].red);
            vs_pulse();
            check("valid_width", got_valid_cycles, 1);
            check("table_box", {g_xmin[10:0], g_xmax[10:0], g_ymin[9:0], g_ymax[9:0],
                                g_cnt[18:0], g_found[0]},
                  {tab[i].xmin[10:0], tab[i].xmax[10:0], tab[i].ymin[9:0], tab[i].ymax[9:0],
                   tab[i].cnt[18:0], tab[i].found[0]});
        end

        for (int r = 0; r < 6; r++) begin
            int nl, w, x0, y0, sw, sh;
            nl = int'($urandom_range(4, 16));
            w  = int'($urandom_range(20, 70));
            sw = int'($urandom_range(1, 12));
            sh = int'($urandom_range(1, 10));
            x0 = int'($urandom_range(0, 50));
            y0 = int'($urandom_range(0, 6));
            fill_img(x0, x0 + sw - 1, y0, y0 + sh - 1);
            for (int k = 0; k < 12; k++)
                img[$urandom_range(0, 15)][$urandom_range(0, 69)] = 1'b1;
            drive_lines(nl, w);
            vs_pulse();
            check("rand_valid_width", got_valid_cycles, 1);
        end

        // Frame boundary landing on a valid '1' pixel.
        fill_img(0, 7, 0, 7);
        drive_lines(8, 40);
        got_valid_cycles = 0;
        cycle(1, 0, 1, 1);
        cycle(0, 0, 1, 0);
        repeat (4) cycle(0, 0, 0, 0);
        check("coincide_valid_width", got_valid_cycles, 1);
        check("coincide_prev_count", g_cnt, 64);
        drive_lines(8, 40);
        vs_pulse();
        check("coincide_next_count", {g_cnt, g_found}, {32'd64, 32'd1});

        // Reset in the middle of a frame containing ones.
        drive_lines(2, 40);
        repeat (5) cycle(1, 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        bin_data = 0; bin_de = 0; bin_hs = 0; bin_vs = 0;
        #1;
        check("midreset_outputs", {out_data, out_de, out_hs, out_vs, box_valid, box_found,
              box_xmin, box_xmax, box_ymin, box_ymax, box_count}, '0);
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        drive_lines(3, 40);
        vs_pulse();
        check("midreset_partial_no_valid", got_valid_cycles, 0);
        drive_lines(8, 40);
        vs_pulse();
        check("midreset_full_frame", {got_valid_cycles[1:0], g_xmin[10:0], g_xmax[10:0],
              g_ymin[9:0], g_ymax[9:0], g_cnt[18:0], g_found[0]},
              {2'd1, 11'd0, 11'd7, 10'd0, 10'd7, 19'd64, 1'b1});
        cycle(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
